controle_entrada_time: RTL and testbench
========================================

Name: controle_entrada_time

Overview:
Sequencer for the oven timer's time-entry and countdown path. Decodes and debounces the one-hot keypad, drives the digit bus D and loadn strobe into the 3-digit BCD time register (M:SS), and sequences entry, cooking, pause and done. It also generates the 1 Hz tick from clk. It sits between the keypad/buttons and the time display/heater drive.

Parameters:
CLK_DIV, 100, clk cycles per pgt_1Hz tick (≥2)
DEBOUNCE, 4, consecutive stable cycles required to accept a key press or release (≥1)

Ports:
clk  input  1  system clock, all state updates on rising edge
clearn  input  1  asynchronous active-low reset
teclado  input  10  one-hot keypad, bit i = digit i; synchronous to clk
enablen  input  1  active-low keypad enable
startn  input  1  active-low start button level
stopn  input  1  active-low stop/clear button level
porta  input  1  1 = door open
D  output  4  BCD digit of last accepted key
loadn  output  1  active-low 1-cycle load strobe for D
pgt_1Hz  output  1  1-cycle tick, active only in COOK
min_u  output  4  minutes units, BCD
seg_d  output  4  seconds tens, BCD
seg_u  output  4  seconds units, BCD
magnetron  output  1  heater enable, high only in COOK
done  output  1  end-of-cook flag

Behaviour:
- Reset (clearn=0, async): state IDLE; D=0000, loadn=1, pgt_1Hz=0, all digits 0, magnetron=0, done=0; divider, debounce counters and button edge registers cleared.
- Key decode: exactly one bit set → valid digit. Zero or multiple bits set → no key.
- enablen=1 → keypad ignored and debounce counter held at 0.
- Debounce: same valid digit for DEBOUNCE consecutive cycles → accept once. Rearm only after DEBOUNCE consecutive no-key cycles. A changed digit restarts the count.
- On accept in IDLE/ENTRY:
  - Next cycle: D=digit, loadn=0 for exactly 1 cycle.
  - Same edge: shift digits (min_u←seg_d, seg_d←seg_u, seg_u←digit); state → ENTRY.
  - Keys are ignored in COOK, PAUSE and DONE.
- startn/stopn: act on falling edge (registered previous value). Both falling in the same cycle → stop wins.
- FSM transitions:
  - IDLE: start ignored.
  - ENTRY: stop → IDLE (digits cleared). Start with time≠000 and porta=0 → COOK; on this transition, if seg_d>5 then seg_d←5 and seg_u←9.
  - COOK: stop or porta=1 → PAUSE.
  - PAUSE: start with porta=0 → COOK; stop → IDLE (clear).
  - DONE: stop, start or any accepted key → IDLE (clear). A key pressed in DONE is consumed and not shifted.
- Divider: cleared on every COOK entry and counts only in COOK. pgt_1Hz=1 on the cycle the count reaches CLK_DIV-1, then wraps to 0. Counter value is frozen in PAUSE.
- Countdown: each tick decrements M:SS in BCD.
  - seg_u 0→9 with borrow; seg_d 0→5 with borrow; min_u decrements on borrow.
  - The tick that produces 0:00 moves state to DONE: magnetron=0, done=1 held.
- porta rising in the same cycle as the final tick → DONE takes priority.
- magnetron is combinationally (state==COOK). done is registered.

Decomposition:
- Shared package forno_pkg: state encoding (IDLE, ENTRY, COOK, PAUSE, DONE), BCD constants (BCD_MAX_U=9, BCD_MAX_D=5), default CLK_DIV/DEBOUNCE.
- One sub-module: teclado_debounce. Inputs teclado, enablen; outputs a 1-cycle accept pulse plus the 4-bit digit; contains the one-hot decode and debounce counter.
- FSM, divider and BCD countdown stay in the top level.

Test Plan:
- Bench setting: CLK_DIV=4, DEBOUNCE=2.
- Reset mid-COOK → all outputs at reset values immediately, without waiting for a clock edge; state IDLE.
- enablen=0, teclado=10'b1000000000 held 10 cycles → exactly one loadn pulse, D=1001, seg_u=9. Then teclado=10'b0100000000 (one-hot key 8), released 2 cycles, then held → second pulse, D=1000, seg_d=9, seg_u=8. With enablen=1 and 10'b0000000100 held → no pulse, digits unchanged.
- Keys 1,0,5 entered (1:05), start falling edge → magnetron=1, pgt_1Hz every 4 cycles; after 65 ticks → done=1, magnetron=0, digits 0:00.
- Keys 0,9,9 entered, start → seg_d clamped to 5, seg_u 9; first tick gives 0:58.
- COOK at 0:10, porta=1 → PAUSE and ticks stop; porta=0 then start → resumes at 0:10 with no lost tick. startn and stopn falling together in COOK → PAUSE.
- teclado=10'b0000000011 held, key glitch shorter than DEBOUNCE, or key pressed during COOK → no loadn pulse, digits unchanged.

Source files
------------

// File: rtl/forno_pkg.sv
// Shared definitions for the oven timer entry/countdown path.
package forno_pkg;

   // Sequencer states.
   typedef enum logic [2:0] {
      StIdle,
      StEntry,
      StCook,
      StPause,
      StDone
   } state_t;

   // Largest value of a seconds-units and a seconds-tens BCD digit.
   localparam int unsigned BCD_MAX_U = 9;
   localparam int unsigned BCD_MAX_D = 5;

   localparam int unsigned CLK_DIV_DEFAULT  = 100;
   localparam int unsigned DEBOUNCE_DEFAULT = 4;

   // Index of the set bit of a one-hot keypad word (caller checks one-hotness).
   function automatic logic [3:0] onehot_to_bcd(input logic [9:0] keys);
      logic [3:0] code;
      code = '0;
      for (int i = 0; i < 10; i++) begin
         if (keys[i]) code = 4'(i);
      end
      return code;
   endfunction

endpackage

// File: rtl/teclado_debounce.sv
// One-hot keypad decode and debounce. Emits a single accept pulse per press;
// a new press is only taken after the keypad has been quiet long enough.
module teclado_debounce
   import forno_pkg::*;
#(
   parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
   input  logic       clk,
   input  logic       clearn,
   input  logic [9:0] teclado,
   input  logic       enablen,
   output logic       accept,
   output logic [3:0] digit
);

   localparam int unsigned CW = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE);

   logic [CW-1:0] cnt_q, cnt_d, run;
   logic [3:0]    last_q, last_d;
   logic          armed_q, armed_d;
   logic          key_valid;

   assign key_valid = $onehot(teclado);
   assign digit     = onehot_to_bcd(teclado);

   // Counts same-key samples while armed and quiet samples while disarmed.
   always_comb begin
      cnt_d   = cnt_q;
      last_d  = last_q;
      armed_d = armed_q;
      accept  = 1'b0;
      run     = CW'(1);
      if (enablen) begin
         cnt_d = '0;
      end else if (armed_q) begin
         if (key_valid) begin
            if (cnt_q != '0 && digit == last_q) run = cnt_q + CW'(1);
            last_d = digit;
            if (run == CNT_TARGET) begin
               accept  = 1'b1;
               armed_d = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = run;
            end
         end else begin
            cnt_d = '0;
         end
      end else begin
         if (!key_valid) begin
            if (cnt_q + CW'(1) == CNT_TARGET) begin
               armed_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end else begin
            cnt_d = '0;
         end
      end
   end

   // Debounce state register.
   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         cnt_q   <= '0;
         last_q  <= '0;
         armed_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         armed_q <= armed_d;
      end
   end

endmodule

// File: rtl/controle_entrada_time.sv
// Oven timer sequencer: key entry into a 3-digit M:SS BCD register, cook
// countdown driven by an internal 1 Hz divider, pause and done handling.
module controle_entrada_time
   import forno_pkg::*;
#(
   parameter int unsigned CLK_DIV  = CLK_DIV_DEFAULT,
   parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
   input  logic       clk,
   input  logic       clearn,
   input  logic [9:0] teclado,
   input  logic       enablen,
   input  logic       startn,
   input  logic       stopn,
   input  logic       porta,
   output logic [3:0] D,
   output logic       loadn,
   output logic       pgt_1Hz,
   output logic [3:0] min_u,
   output logic [3:0] seg_d,
   output logic [3:0] seg_u,
   output logic       magnetron,
   output logic       done
);

   localparam int unsigned DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [3:0] MAX_U = 4'(BCD_MAX_U);
   localparam logic [3:0] MAX_D = 4'(BCD_MAX_D);

   state_t        state_q, state_d;
   logic [3:0]    min_q, min_d, sd_q, sd_d, su_q, su_d;
   logic [3:0]    dec_min, dec_sd, dec_su;
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    d_q, d_d;
   logic          loadn_q, loadn_d;
   logic          done_q, done_d;
   logic          startn_q, stopn_q;
   logic          accept;
   logic [3:0]    key_digit;
   logic          tick, last_tick, time_nz;
   logic          start_fall, stop_fall, start_ev;
   logic          load, clear;

   teclado_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk     (clk),
      .clearn  (clearn),
      .teclado (teclado),
      .enablen (enablen),
      .accept  (accept),
      .digit   (key_digit)
   );

   assign start_fall = startn_q & ~startn;
   assign stop_fall  = stopn_q & ~stopn;
   assign start_ev   = start_fall & ~stop_fall;
   assign tick       = (state_q == StCook) && (div_q == DIV_LAST);
   assign time_nz    = (min_q != 4'd0) || (sd_q != 4'd0) || (su_q != 4'd0);
   assign last_tick  = (min_q == 4'd0) && (sd_q == 4'd0) && (su_q == 4'd1);

   // BCD M:SS minus one second.
   always_comb begin
      dec_min = min_q;
      dec_sd  = sd_q;
      dec_su  = su_q;
      if (su_q != 4'd0) begin
         dec_su = su_q - 4'd1;
      end else begin
         dec_su = MAX_U;
         if (sd_q != 4'd0) begin
            dec_sd = sd_q - 4'd1;
         end else begin
            dec_sd  = MAX_D;
            dec_min = min_q - 4'd1;
         end
      end
   end

   // Next state, digit register, divider and load strobe.
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sd_d    = sd_q;
      su_d    = su_q;
      div_d   = div_q;
      d_d     = d_q;
      loadn_d = 1'b1;
      load    = 1'b0;
      clear   = 1'b0;
      unique case (state_q)
         StIdle: load = accept;
         StEntry: begin
            if (stop_fall) begin
               clear = 1'b1;
            end else if (start_ev && time_nz && !porta) begin
               state_d = StCook;
               div_d   = '0;
               // Entered seconds beyond 59 cook as 59.
               if (sd_q > MAX_D) begin
                  sd_d = MAX_D;
                  su_d = MAX_U;
               end
            end else begin
               load = accept;
            end
         end
         StCook: begin
            div_d = tick ? '0 : div_q + DW'(1);
            if (tick) begin
               min_d = dec_min;
               sd_d  = dec_sd;
               su_d  = dec_su;
            end
            // Reaching 0:00 wins over a simultaneous door open or stop.
            if (tick && last_tick) state_d = StDone;
            else if (stop_fall || porta) state_d = StPause;
         end
         StPause: begin
            if (stop_fall) begin
               clear = 1'b1;
            end else if (start_ev && !porta) begin
               state_d = StCook;
               div_d   = '0;
            end
         end
         StDone: begin
            // A key here only returns to idle; it is not loaded.
            if (stop_fall || start_fall || accept) clear = 1'b1;
         end
         default: clear = 1'b1;
      endcase
      if (clear) begin
         state_d = StIdle;
         min_d   = '0;
         sd_d    = '0;
         su_d    = '0;
      end
      if (load) begin
         state_d = StEntry;
         min_d   = sd_q;
         sd_d    = su_q;
         su_d    = key_digit;
         d_d     = key_digit;
         loadn_d = 1'b0;
      end
      done_d = (state_d == StDone);
   end

   // State, digits, divider, outputs and button history.
   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         state_q  <= StIdle;
         min_q    <= '0;
         sd_q     <= '0;
         su_q     <= '0;
         div_q    <= '0;
         d_q      <= '0;
         loadn_q  <= 1'b1;
         done_q   <= 1'b0;
         startn_q <= 1'b0;
         stopn_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         min_q    <= min_d;
         sd_q     <= sd_d;
         su_q     <= su_d;
         div_q    <= div_d;
         d_q      <= d_d;
         loadn_q  <= loadn_d;
         done_q   <= done_d;
         startn_q <= startn;
         stopn_q  <= stopn;
      end
   end

   assign D         = d_q;
   assign loadn     = loadn_q;
   assign pgt_1Hz   = tick;
   assign min_u     = min_q;
   assign seg_d     = sd_q;
   assign seg_u     = su_q;
   assign magnetron = (state_q == StCook);
   assign done      = done_q;

endmodule

// File: tb/tb_controle_entrada_time.sv
// Directed bench for controle_entrada_time with a seconds-based reference model.
module tb_controle_entrada_time;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned DEB     = 2;
   localparam int MIdle = 0, MEntry = 1, MCook = 2, MPause = 3, MDone = 4;

   logic       clk = 1'b0;
   logic       clearn = 1'b1;
   logic [9:0] teclado = '0;
   logic       enablen = 1'b0, startn = 1'b1, stopn = 1'b1, porta = 1'b0;
   logic [3:0] D, min_u, seg_d, seg_u;
   logic       loadn, pgt_1Hz, magnetron, done;

   int total = 0, bad = 0;
   int nload = 0, npgt = 0;
   bit run_chk = 1'b0;

   // Reference model: entered digits, cook time in whole seconds, key history.
   int m_st, secs, mdiv, mD, mloadn, mdone, pstart, pstop, armed;
   int dig[3];
   int hist[DEB];

   always #5 clk = ~clk;

   controle_entrada_time #(
      .CLK_DIV  (CLK_DIV),
      .DEBOUNCE (DEB)
   ) dut (
      .clk       (clk),
      .clearn    (clearn),
      .teclado   (teclado),
      .enablen   (enablen),
      .startn    (startn),
      .stopn     (stopn),
      .porta     (porta),
      .D         (D),
      .loadn     (loadn),
      .pgt_1Hz   (pgt_1Hz),
      .min_u     (min_u),
      .seg_d     (seg_d),
      .seg_u     (seg_u),
      .magnetron (magnetron),
      .done      (done)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mreset();
      m_st = MIdle; secs = 0; mdiv = 0; mD = 0; mloadn = 1; mdone = 0;
      pstart = 0; pstop = 0; armed = 1;
      for (int i = 0; i < 3; i++) dig[i] = 0;
      for (int i = 0; i < DEB; i++) hist[i] = 11;
   endtask

   task automatic mclear();
      m_st = MIdle;
      for (int i = 0; i < 3; i++) dig[i] = 0;
   endtask

   task automatic mload(input int k);
      dig[0] = dig[1]; dig[1] = dig[2]; dig[2] = k;
      mD = k; mloadn = 0; m_st = MEntry;
   endtask

   task automatic mstep();
      int cnt, idx, tok;
      bit same, quiet, acc, tk, sf, pf, sev;
      cnt = 0; idx = 0;
      for (int i = 0; i < 10; i++) if (teclado[i]) begin cnt++; idx = i; end
      // Sample token: 0..9 key, 10 no key, 11 keypad disabled.
      tok = enablen ? 11 : (cnt == 1 ? idx : 10);
      for (int i = 0; i < DEB - 1; i++) hist[i] = hist[i+1];
      hist[DEB-1] = tok;
      same = (hist[0] < 10); quiet = 1'b1;
      for (int i = 0; i < DEB; i++) begin
         if (hist[i] != hist[0]) same = 1'b0;
         if (hist[i] != 10) quiet = 1'b0;
      end
      acc = armed && same;
      if (acc) armed = 0;
      else if (!armed && quiet) armed = 1;

      tk  = (m_st == MCook) && (mdiv == CLK_DIV - 1);
      pf  = pstop && !stopn;
      sf  = pstart && !startn;
      sev = sf && !pf;
      pstart = startn; pstop = stopn; mloadn = 1;
      case (m_st)
         MIdle: if (acc) mload(idx);
         MEntry: begin
            if (pf) mclear();
            else if (sev && (dig[0] + dig[1] + dig[2]) != 0 && !porta) begin
               secs = dig[0] * 60 + (dig[1] > 5 ? 59 : dig[1] * 10 + dig[2]);
               m_st = MCook; mdiv = 0;
            end else if (acc) mload(idx);
         end
         MCook: begin
            if (tk) begin secs--; mdiv = 0; end
            else mdiv++;
            if (tk && secs == 0) m_st = MDone;
            else if (pf || porta) m_st = MPause;
         end
         MPause: begin
            if (pf) mclear();
            else if (sev && !porta) begin m_st = MCook; mdiv = 0; end
         end
         MDone: if (pf || sf || acc) mclear();
         default: mclear();
      endcase
      mdone = (m_st == MDone);
   endtask

   always @(posedge clk or negedge clearn) begin
      if (!clearn) mreset();
      else mstep();
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      int em, ed, eu;
      if (run_chk && clearn) begin
         if (m_st == MIdle || m_st == MEntry) begin
            em = dig[0]; ed = dig[1]; eu = dig[2];
         end else begin
            em = secs / 60; ed = (secs % 60) / 10; eu = secs % 10;
         end
         check("D", D, mD);
         check("loadn", loadn, mloadn);
         check("pgt_1Hz", pgt_1Hz, (m_st == MCook && mdiv == CLK_DIV - 1) ? 1 : 0);
         check("min_u", min_u, em);
         check("seg_d", seg_d, ed);
         check("seg_u", seg_u, eu);
         check("magnetron", magnetron, (m_st == MCook) ? 1 : 0);
         check("done", done, mdone);
         if (!loadn) nload++;
         if (pgt_1Hz) npgt++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int k);
      teclado = 10'b1 << k;
      cyc(3);
      teclado = '0;
      cyc(3);
   endtask

   task automatic pulse_start();
      startn = 1'b0; cyc(2); startn = 1'b1; cyc(1);
   endtask

   task automatic pulse_stop();
      stopn = 1'b0; cyc(2); stopn = 1'b1; cyc(1);
   endtask

   initial begin
      int n0, p0, n;
      mreset();
      #2 clearn = 1'b0;
      #1;
      check("rst_D", D, 0);
      check("rst_loadn", loadn, 1);
      check("rst_digits", {min_u, seg_d, seg_u}, 0);
      check("rst_done", done, 0);
      cyc(2);
      clearn = 1'b1;
      run_chk = 1'b1;
      cyc(2);

      // Held key gives one load; re-press after release gives another.
      n0 = nload;
      teclado = 10'b1000000000; cyc(10); teclado = '0; cyc(3);
      check("key9_pulses", nload - n0, 1);
      check("key9_D", D, 9);
      check("key9_seg_u", seg_u, 9);
      teclado = 10'b0100000000; cyc(10); teclado = '0; cyc(3);
      check("key8_pulses", nload - n0, 2);
      check("key8_D", D, 8);
      check("key8_digits", {min_u, seg_d, seg_u}, 12'h098);
      enablen = 1'b1; teclado = 10'b0000000100; cyc(6);
      teclado = '0; enablen = 1'b0; cyc(3);
      check("disabled_pulses", nload - n0, 2);
      check("disabled_digits", {min_u, seg_d, seg_u}, 12'h098);
      pulse_stop();
      check("entry_stop_clear", {min_u, seg_d, seg_u}, 0);

      // 1:05 cooks for 65 ticks then reports done.
      press(1); press(0); press(5);
      check("entry_105", {min_u, seg_d, seg_u}, 12'h105);
      p0 = npgt;
      startn = 1'b0; cyc(1);
      check("cook_magnetron", magnetron, 1);
      startn = 1'b1;
      for (int i = 0; i < 400 && !done; i++) cyc(1);
      check("cook_done_reached", done, 1);
      check("cook_ticks", npgt - p0, 65);
      check("done_magnetron", magnetron, 0);
      check("done_digits", {min_u, seg_d, seg_u}, 0);
      n0 = nload;
      press(4);
      check("done_key_no_load", nload - n0, 0);
      check("done_key_exit", done, 0);
      check("done_key_D", D, 5);

      // 0:99 is clamped to 0:59.
      press(0); press(9); press(9);
      startn = 1'b0; cyc(1);
      check("clamp_059", {min_u, seg_d, seg_u}, 12'h059);
      startn = 1'b1;
      for (int i = 0; i < 10 && !pgt_1Hz; i++) cyc(1);
      check("clamp_tick_seen", pgt_1Hz, 1);
      cyc(1);
      check("clamp_058", {min_u, seg_d, seg_u}, 12'h058);
      pulse_stop(); pulse_stop();

      // Door pause and resume at 0:10.
      press(0); press(1); press(0);
      startn = 1'b0; cyc(1); startn = 1'b1; cyc(1);
      porta = 1'b1; cyc(1);
      check("pause_magnetron", magnetron, 0);
      p0 = npgt; cyc(8);
      check("pause_no_ticks", npgt - p0, 0);
      check("pause_digits", {min_u, seg_d, seg_u}, 12'h010);
      porta = 1'b0; cyc(1);
      startn = 1'b0; cyc(1);
      check("resume_magnetron", magnetron, 1);
      startn = 1'b1;
      n = 1;
      while (!pgt_1Hz && n < 20) begin cyc(1); n++; end
      check("resume_tick_latency", n, 4);
      check("resume_at_010", {min_u, seg_d, seg_u}, 12'h010);
      cyc(1);
      check("resume_009", {min_u, seg_d, seg_u}, 12'h009);
      startn = 1'b0; stopn = 1'b0; cyc(1);
      check("both_fall_pause", magnetron, 0);
      startn = 1'b1; stopn = 1'b1; cyc(1);
      pulse_stop();
      check("pause_stop_clear", {min_u, seg_d, seg_u}, 0);

      // Door opening on the final tick still ends in done.
      press(0); press(0); press(1);
      startn = 1'b0; cyc(1); startn = 1'b1;
      for (int i = 0; i < 10 && !pgt_1Hz; i++) cyc(1);
      porta = 1'b1; cyc(1);
      check("final_tick_door_done", done, 1);
      porta = 1'b0;
      pulse_stop();
      check("final_done_cleared", done, 0);

      // Rejected key patterns.
      press(5);
      n0 = nload;
      teclado = 10'b0000000011; cyc(6); teclado = '0; cyc(3);
      teclado = 10'b0000001000; cyc(1); teclado = '0; cyc(3);
      check("reject_no_load", nload - n0, 0);
      check("reject_digits", {min_u, seg_d, seg_u}, 12'h005);
      pulse_start();
      press(7);
      check("cook_key_no_load", nload - n0, 0);
      pulse_stop(); pulse_stop();

      // Asynchronous reset in the middle of cooking.
      press(1); press(0); press(5);
      startn = 1'b0; cyc(1); startn = 1'b1; cyc(5);
      @(posedge clk);
      #2 clearn = 1'b0;
      #1;
      check("arst_magnetron", magnetron, 0);
      check("arst_D", D, 0);
      check("arst_digits", {min_u, seg_d, seg_u}, 0);
      check("arst_pgt", pgt_1Hz, 0);
      check("arst_loadn", loadn, 1);
      check("arst_done", done, 0);
      cyc(1);
      clearn = 1'b1;
      cyc(2);
      pulse_start();
      check("arst_idle_ignores_start", magnetron, 0);
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
